// File: rtl/pixel_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_word_packer_pkg
// Description : Shared pixel-stream definitions for the ray-marcher pixel path.
//               Phase encodings of the 4-pixel / 3-word packing group, stream
//               widths and line geometry (also used by the coordinate
//               generator).
// Revision    : 1.0  initial release
// ============================================================================
package pixel_word_packer_pkg;

  // Stream widths
  localparam int PIX_W  = 24;
  localparam int WORD_W = 32;

  // Line geometry of the ray-marcher output
  localparam int LINE_W  = 640;
  localparam int FRAME_H = 480;

  // Position of the next incoming pixel inside a 4-pixel packing group
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  // Run/flush flag: FLUSH means a residue word must still be emitted
  localparam logic RUN   = 1'b0;
  localparam logic FLUSH = 1'b1;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage : pixel_word_packer_pkg
`default_nettype wire

// File: rtl/pixel_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_word_packer
// Description : Packs a 24-bit RGB pixel stream (one pixel per handshake) into
//               32-bit AXI4-Stream words, 4 pixels -> 3 words, little-endian
//               byte order. sof maps to tuser, eol to tlast; a line ending
//               mid-group is closed with a PAD_BYTE-filled word.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk               in   1   stream clock, rising edge
//   aresetn            in   1   asynchronous active-low reset
//   r, g, b            in   8   pixel colour, pixel = {r,g,b}
//   valid              in   1   pixel valid
//   sof                in   1   first pixel of frame (qualified by valid)
//   eol                in   1   last pixel of line (qualified by valid)
//   in_stream_ready    out  1   pixel accepted when valid && in_stream_ready
//   out_stream_tdata   out  32  packed word
//   out_stream_tkeep   out  4   constant 4'hF
//   out_stream_tlast   out  1   last word of line
//   out_stream_tuser   out  1   first word of frame
//   out_stream_tvalid  out  1   AXIS valid
//   out_stream_tready  in   1   AXIS ready
// ============================================================================
module pixel_word_packer
  import pixel_word_packer_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic              valid,
  input  logic              sof,
  input  logic              eol,
  output logic              in_stream_ready,
  output logic [WORD_W-1:0] out_stream_tdata,
  output logic [3:0]        out_stream_tkeep,
  output logic              out_stream_tlast,
  output logic              out_stream_tuser,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready
);

  // Group phase / flush state
  logic [1:0]  phase_q, phase_d;
  logic        flush_q, flush_d;
  // Up to three bytes carried between pixels of a group (LSB-aligned)
  logic [23:0] residue_q, residue_d;
  logic        sof_pend_q, sof_pend_d;

  // Output register
  word_t       tdata_q, tdata_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        tvalid_q, tvalid_d;

  pixel_t      pix;
  logic        obuf_free;
  logic        accept;
  logic        sof_now;
  logic        load;
  word_t       ld_data;
  logic        ld_last;
  logic        ld_user;

  assign pix       = {r, g, b};
  assign obuf_free = !tvalid_q || out_stream_tready;
  // A P0 pixel without eol only fills the residue, so it never needs obuf.
  assign in_stream_ready = aresetn && (flush_q == RUN) &&
                           (((phase_q == P0) && !eol) || obuf_free);
  assign accept    = valid && in_stream_ready;
  assign sof_now   = sof_pend_q || sof;

  always_comb begin
    phase_d    = phase_q;
    flush_d    = flush_q;
    residue_d  = residue_q;
    sof_pend_d = sof_pend_q;
    load       = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    ld_user    = 1'b0;

    if (flush_q == FLUSH) begin
      // phase_q is P2 when two residue bytes remain, P3 when one remains.
      if (obuf_free) begin
        load       = 1'b1;
        ld_last    = 1'b1;
        ld_user    = sof_pend_q;
        sof_pend_d = 1'b0;
        flush_d    = RUN;
        phase_d    = P0;
        residue_d  = '0;
        if (phase_q == P2) begin
          ld_data = {PAD_BYTE, PAD_BYTE, residue_q[15:0]};
        end else begin
          ld_data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, residue_q[7:0]};
        end
      end
    end else if (accept) begin
      case (phase_q)
        P0: begin
          if (eol) begin
            load       = 1'b1;
            ld_data    = {PAD_BYTE, pix};
            ld_last    = 1'b1;
            ld_user    = sof_now;
            sof_pend_d = 1'b0;
          end else begin
            residue_d  = pix;
            sof_pend_d = sof_now;
            phase_d    = P1;
          end
        end
        P1: begin
          load       = 1'b1;
          ld_data    = {pix[7:0], residue_q};
          ld_user    = sof_now;
          sof_pend_d = 1'b0;
          residue_d  = {8'h00, pix[23:8]};
          phase_d    = P2;
          flush_d    = eol ? FLUSH : RUN;
        end
        P2: begin
          load       = 1'b1;
          ld_data    = {pix[15:0], residue_q[15:0]};
          ld_user    = sof_now;
          sof_pend_d = 1'b0;
          residue_d  = {16'h0000, pix[23:16]};
          phase_d    = P3;
          flush_d    = eol ? FLUSH : RUN;
        end
        default: begin
          load       = 1'b1;
          ld_data    = {pix, residue_q[7:0]};
          ld_last    = eol;
          ld_user    = sof_now;
          sof_pend_d = 1'b0;
          residue_d  = '0;
          phase_d    = P0;
        end
      endcase
    end
  end

  // Output register: loads when free, otherwise holds while stalled.
  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tdata_d  = ld_data;
      tlast_d  = ld_last;
      tuser_d  = ld_user;
      tvalid_d = 1'b1;
    end else if (tvalid_q && out_stream_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q    <= P0;
      flush_q    <= RUN;
      residue_q  <= '0;
      sof_pend_q <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      flush_q    <= flush_d;
      residue_q  <= residue_d;
      sof_pend_q <= sof_pend_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign out_stream_tdata  = tdata_q;
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tvalid = tvalid_q;

endmodule : pixel_word_packer
`default_nettype wire

// File: tb/tb_pixel_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_word_packer
// Description : Self-checking bench for pixel_word_packer. Accepted pixels feed
//               a byte-stream reference model whose words go into a scoreboard
//               queue; a monitor pops and compares every output beat.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_word_packer;

  localparam logic [7:0] PAD = 8'hEE;

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic        user;
  } exp_word_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
  logic        out_stream_tready;

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  int tr_mode = 1;  // 0 random, 1 high, 2 low

  exp_word_t   exp_q[$];
  logic [7:0]  bq[$];
  bit          m_sof = 1'b0;

  bit          stall_prev = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l, stall_u;

  always #5 aclk = ~aclk;

  pixel_word_packer #(.PAD_BYTE(PAD)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: the line is a little-endian byte stream cut into 32-bit
  // words; eol pads out the last partial word and marks it last.
  function automatic void model_push(input logic [23:0] p, input bit s, input bit e);
    exp_word_t w;
    if (s) m_sof = 1'b1;
    for (int i = 0; i < 3; i++) bq.push_back(p[8*i +: 8]);
    while (bq.size() >= 4 || (e && bq.size() > 0)) begin
      w.d = '0;
      for (int k = 0; k < 4; k++) begin
        if (bq.size() > 0) w.d[8*k +: 8] = bq.pop_front();
        else               w.d[8*k +: 8] = PAD;
      end
      w.last = e && (bq.size() == 0);
      w.user = m_sof;
      m_sof  = 1'b0;
      exp_q.push_back(w);
    end
  endfunction

  task automatic send(input logic [23:0] p, input bit s, input bit e, output int waits);
    waits = 0;
    {r, g, b} = p;
    sof = s; eol = e; valid = 1'b1;
    @(negedge aclk);
    while (!in_stream_ready && waits <= 300) begin
      waits++;
      @(negedge aclk);
    end
    if (in_stream_ready) model_push(p, s, e);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: pixel %h never accepted", p);
    end
    @(posedge aclk); #1;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge aclk); #1;
  endtask

  // tready driver
  initial begin
    out_stream_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (tr_mode)
        0:       out_stream_tready = ($urandom_range(0, 3) != 0);
        1:       out_stream_tready = 1'b1;
        default: out_stream_tready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_word_t w;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (stall_prev) begin
          chk("hold_tvalid", out_stream_tvalid, 1);
          chk("hold_tdata",  out_stream_tdata, stall_d);
          chk("hold_tlast",  out_stream_tlast, stall_l);
          chk("hold_tuser",  out_stream_tuser, stall_u);
        end
        if (out_stream_tvalid && out_stream_tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h, expected no word", out_stream_tdata);
          end else begin
            w = exp_q.pop_front();
            chk("tdata", out_stream_tdata, w.d);
            chk("tlast", out_stream_tlast, w.last);
            chk("tuser", out_stream_tuser, w.user);
            chk("tkeep", out_stream_tkeep, 4'hF);
          end
        end
        stall_prev = out_stream_tvalid && !out_stream_tready;
        stall_d    = out_stream_tdata;
        stall_l    = out_stream_tlast;
        stall_u    = out_stream_tuser;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wsum, b0;
    logic [23:0] p;
    aresetn = 1'b0;
    {r, g, b} = '0; valid = 1'b0; sof = 1'b0; eol = 1'b0;

    // Reset state
    #3;
    chk("rst_tvalid", out_stream_tvalid, 0);
    chk("rst_tdata",  out_stream_tdata, 0);
    chk("rst_tlast",  out_stream_tlast, 0);
    chk("rst_tuser",  out_stream_tuser, 0);
    #19 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_ready", in_stream_ready, 1);

    // Full group, back to back
    b0 = beats;
    send(24'h112233, 1'b0, 1'b0, w);
    send(24'h445566, 1'b0, 1'b0, w);
    send(24'h778899, 1'b0, 1'b0, w);
    send(24'hAABBCC, 1'b0, 1'b1, w);
    drain();
    chk("group_beats", beats - b0, 3);

    // 640-pixel line
    b0 = beats; wsum = 0;
    for (int i = 0; i < 640; i++) begin
      send($urandom, i == 0, i == 639, w);
      wsum += w;
    end
    drain();
    chk("line_beats", beats - b0, 480);
    chk("line_ready_drops", wsum, 0);

    // eol on the second pixel: flush word, ready low for one cycle
    send(24'h010203, 1'b1, 1'b0, w);
    send(24'h040506, 1'b0, 1'b1, w);
    send(24'h070809, 1'b0, 1'b1, w);
    chk("flush_ready_low_cycles", w, 1);
    drain();

    // Backpressure
    tr_mode = 2; out_stream_tready = 1'b0;
    send(24'h100000, 1'b0, 1'b0, w);
    send(24'h200000, 1'b0, 1'b0, w);
    fork
      send(24'h300000, 1'b0, 1'b0, w);
      begin repeat (5) @(posedge aclk); #1; tr_mode = 1; out_stream_tready = 1'b1; end
    join
    chk("stall_ready_low", (w > 0), 1);
    send(24'h400000, 1'b0, 1'b0, w);
    tr_mode = 2; out_stream_tready = 1'b0;
    send(24'h500000, 1'b0, 1'b0, w);
    chk("stall_p0_ready", w, 0);
    fork
      send(24'h600000, 1'b0, 1'b1, w);
      begin repeat (5) @(posedge aclk); #1; tr_mode = 1; out_stream_tready = 1'b1; end
    join
    drain();

    // Asynchronous reset mid-group with a word held in obuf
    tr_mode = 2; out_stream_tready = 1'b0;
    send(24'h0A0B0C, 1'b1, 1'b0, w);
    send(24'h0D0E0F, 1'b0, 1'b0, w);
    #2 aresetn = 1'b0;
    #1 chk("async_rst_tvalid", out_stream_tvalid, 0);
    exp_q.delete(); bq.delete(); m_sof = 1'b0; stall_prev = 1'b0;
    tr_mode = 1; out_stream_tready = 1'b1;
    @(negedge aclk); @(negedge aclk); #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    send(24'hABCDEF, 1'b0, 1'b0, w);
    send(24'h123456, 1'b0, 1'b0, w);
    send(24'h789ABC, 1'b0, 1'b0, w);
    send(24'hDEF012, 1'b0, 1'b1, w);
    drain();

    // Single-pixel line with sof and eol
    b0 = beats;
    send(24'hABCDEF, 1'b1, 1'b1, w);
    drain();
    chk("single_beats", beats - b0, 1);

    // Randomized lines, gaps, random backpressure, stray sof
    tr_mode = 0;
    for (int ln = 0; ln < 12; ln++) begin
      int len;
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        p = $urandom;
        send(p, (i == 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 7) == 0),
             i == len - 1, w);
        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      end
    end
    tr_mode = 1; out_stream_tready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pixel_word_packer
`default_nettype wire
